snn_spike_axis_tx: RTL and testbench
====================================

# snn_spike_axis_tx

Transmit side of the SNN neuron-data stream. For one inference window of TS time steps, the block captures the first-spike time step of every neuron across all T blocks. It then serializes those times as AXI4-Stream beats, one beat per neuron, NN bytes wide. It sits between the neuron-block array and the host-facing AXI4-Stream egress.

## Interface
Parameters (defaults from snn_pkg):
- N, 2, neurons per block
- T, 2, number of blocks
- TS, 5, time steps per inference (ALPHA)
- NN, 1, bytes per neuron record

Derived:
- NT = N*T, total neurons
- W = $clog2(TS+1), spike-time width

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- start  in  1  begin new inference window
- spike_valid  in  1  one time step of spikes presented this cycle
- spike  in  NT  spike bits for the current step; neuron index = b*N+n
- busy  out  1  high in CAPTURE or SEND
- done  out  1  one-cycle pulse on the final stream handshake
- m_axis_tdata  out  8*NN  neuron record: first-spike time zero-extended from W bits
- m_axis_tvalid  out  1  record valid
- m_axis_tready  in  1  downstream ready
- m_axis_tlast  out  1  high on the record for neuron NT-1

## Operation
- The FSM has three states: IDLE, CAPTURE and SEND. Reset enters IDLE.
- **IDLE.** When start=1:
  - all NT time registers load TS, which encodes "no spike";
  - the step counter clears to 0;
  - the FSM goes to CAPTURE.
- **CAPTURE.** Each cycle with spike_valid=1:
  - for every neuron i with spike[i]=1 and time[i]==TS, time[i] loads the current step;
  - the step counter increments.
- When spike_valid=1 and step==TS-1, the FSM goes to SEND with index=0.
- Only the first spike per neuron is recorded. Later spikes are ignored.
- Cycles with spike_valid=0 do not advance the step counter. Gaps are allowed.
- **SEND.** The block presents record[index] with tvalid=1.
  - Each handshake (tvalid && tready) increments index.
  - tlast = (index==NT-1).
  - The handshake with tlast=1 pulses done and returns the FSM to IDLE.
- Ignored inputs:
  - start outside IDLE;
  - spike_valid outside CAPTURE.
- Step counter width: $clog2(TS). It never wraps, because the FSM leaves CAPTURE at TS-1.
- Recorded values are 0..TS-1; the value TS means the neuron never spiked. Bits above W in tdata are 0.

## Timing
- Reset values:
  - busy, done, m_axis_tvalid, m_axis_tlast: 0;
  - m_axis_tdata: 0;
  - time registers: TS;
  - step, index: 0.
- Reset asserted mid-CAPTURE or mid-SEND takes effect the next cycle: the FSM is in IDLE and tvalid=0. A partial stream is abandoned and no done pulse is issued.
- start at cycle k: busy=1 at k+1, and spike_valid is accepted from k+1.
- Last spike_valid at cycle k: that step's spikes are recorded, and tvalid=1 with record 0 at k+1.
- All outputs are registered.
- While tvalid=1 and tready=0, tdata and tlast hold stable.
- Back-to-back handshakes give one record per cycle. A full stream takes NT cycles with tready held high.
- done is high in the cycle after the final handshake, with tvalid=0 in that cycle. busy=0 in the same cycle.
- start in the same cycle done is high is accepted (the FSM is already in IDLE).

## Structure
- snn_pkg gains:
  - localparam NT = N*T;
  - localparam SW = $clog2(TS+1);
  - typedef logic [SW-1:0] spike_time_t.
- snn_pkg already provides N, T, TS and NN.
- Sub-module snn_first_spike_capture holds:
  - the NT spike_time_t registers;
  - the step counter and first-spike update logic.
  Its ports are clear, spike_valid, spike, step_last and the times array.
- The top level holds the FSM, the index counter and the AXI4-Stream output register.

## Test plan
With N=2, T=2, TS=5 (NT=4, W=3, NN=1):
- **No spikes.** start, then 5 spike_valid with spike=0 -> 4 beats, tdata=5,5,5,5, tlast on beat 4, done pulse once.
- **Spike times recorded.** Neuron 0 spikes at step 0 and neuron 3 at step 4 -> tdata=0,5,5,4.
- **First spike only.** Neuron 1 spikes at steps 1, 2 and 3 -> its record is 1. A start pulsed during CAPTURE has no effect.
- **Gapped spike_valid and backpressure.** spike_valid is gapped (valid every third cycle), and tready is held low for 3 cycles on beat 2 -> step count is correct, beat 2 tdata is held, no beat is lost or duplicated, and order is 0..3.
- **Reset during SEND.** reset after beat 1 -> tvalid=0 the next cycle, busy=0, no done. A following start/capture streams fresh values (all 5 with no spikes).
- **Back-to-back inferences.** start in the same cycle as done -> the second inference captures correctly and its time registers are reinitialized to 5.

Source files
------------

// File: rtl/snn_pkg.sv
// Shared parameters, types and helpers for the SNN spike-time AXI4-Stream transmitter.
package snn_pkg;

  localparam int N  = 2;
  localparam int T  = 2;
  localparam int TS = 5;
  localparam int NN = 1;

  localparam int NT = N * T;
  localparam int SW = $clog2(TS + 1);
  localparam int DW = 8 * NN;

  typedef logic [SW-1:0] spike_time_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CAPTURE,
    S_SEND
  } tx_state_t;

  // Zero-extend a spike time into one stream record.
  function automatic logic [DW-1:0] to_record(input spike_time_t t);
    logic [DW-1:0] rec;
    rec = '0;
    rec[SW-1:0] = t;
    return rec;
  endfunction

endpackage

// File: rtl/snn_first_spike_capture.sv
// First-spike time registers and step counter for one inference window.
module snn_first_spike_capture
  import snn_pkg::*;
(
  input  logic          clk,
  input  logic          reset,
  input  logic          clear,
  input  logic          spike_valid,
  input  logic [NT-1:0] spike,
  output logic          step_last,
  output spike_time_t   times [NT]
);

  localparam int STEP_W = (TS > 1) ? $clog2(TS) : 1;

  logic [STEP_W-1:0] r_step;
  spike_time_t       r_times [NT];
  logic              w_step_last;

  assign w_step_last = spike_valid && (r_step == STEP_W'(TS - 1));

  // TS in a time register means "no spike yet", so only the first spike sticks.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      r_step <= '0;
      for (int i = 0; i < NT; i++) r_times[i] <= spike_time_t'(TS);
    end else if (spike_valid) begin
      for (int i = 0; i < NT; i++) begin
        if (spike[i] && (r_times[i] == spike_time_t'(TS)))
          r_times[i] <= SW'(r_step);
      end
      if (!w_step_last) r_step <= r_step + 1'b1;
    end
  end

  assign step_last = w_step_last;
  assign times     = r_times;

endmodule

// File: rtl/snn_spike_axis_tx.sv
// Captures first-spike times over one inference window, then streams one
// AXI4-Stream record per neuron.
module snn_spike_axis_tx
  import snn_pkg::*;
(
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          spike_valid,
  input  logic [NT-1:0] spike,
  output logic          busy,
  output logic          done,
  output logic [DW-1:0] m_axis_tdata,
  output logic          m_axis_tvalid,
  input  logic          m_axis_tready,
  output logic          m_axis_tlast
);

  localparam int IW = (NT > 1) ? $clog2(NT) : 1;

  tx_state_t     r_state, w_state_nxt;
  logic          w_clear, w_cap_valid, w_step_last, w_hs;
  spike_time_t   w_times [NT];
  spike_time_t   w_rec0;
  logic [IW-1:0] r_index, w_index_nxt;
  logic          r_busy, r_done, r_tvalid, r_tlast;
  logic [DW-1:0] r_tdata;

  assign w_clear     = (r_state == S_IDLE) && start;
  assign w_cap_valid = (r_state == S_CAPTURE) && spike_valid;
  assign w_hs        = r_tvalid && m_axis_tready;
  assign w_index_nxt = r_index + 1'b1;

  snn_first_spike_capture u_capture (
    .clk        (clk),
    .reset      (reset),
    .clear      (w_clear),
    .spike_valid(w_cap_valid),
    .spike      (spike),
    .step_last  (w_step_last),
    .times      (w_times)
  );

  // Record 0 leaves with the final step, so fold that step's spike in directly.
  assign w_rec0 = (spike[0] && (w_times[0] == spike_time_t'(TS)))
                ? spike_time_t'(TS - 1) : w_times[0];

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:    if (start)              w_state_nxt = S_CAPTURE;
      S_CAPTURE: if (w_step_last)        w_state_nxt = S_SEND;
      S_SEND:    if (w_hs && r_tlast)    w_state_nxt = S_IDLE;
      default:                           w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_tvalid <= 1'b0;
      r_tlast  <= 1'b0;
      r_tdata  <= '0;
      r_index  <= '0;
    end else begin
      r_busy <= (w_state_nxt != S_IDLE);
      r_done <= 1'b0;
      case (r_state)
        S_CAPTURE: begin
          if (w_step_last) begin
            r_tvalid <= 1'b1;
            r_index  <= '0;
            r_tdata  <= to_record(w_rec0);
            r_tlast  <= (NT == 1);
          end
        end
        S_SEND: begin
          if (w_hs) begin
            if (r_tlast) begin
              r_tvalid <= 1'b0;
              r_tlast  <= 1'b0;
              r_done   <= 1'b1;
              r_index  <= '0;
            end else begin
              r_index  <= w_index_nxt;
              r_tdata  <= to_record(w_times[w_index_nxt]);
              r_tlast  <= (w_index_nxt == IW'(NT - 1));
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign busy          = r_busy;
  assign done          = r_done;
  assign m_axis_tdata  = r_tdata;
  assign m_axis_tvalid = r_tvalid;
  assign m_axis_tlast  = r_tlast;

endmodule

// File: tb/tb_snn_spike_axis_tx.sv
// Directed bench for snn_spike_axis_tx with N=2, T=2, TS=5 (four neurons).
module tb_snn_spike_axis_tx;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic       spike_valid;
  logic [3:0] spike;
  logic       busy;
  logic       done;
  logic [7:0] m_axis_tdata;
  logic       m_axis_tvalid;
  logic       m_axis_tready;
  logic       m_axis_tlast;

  int n_cmp = 0;
  int n_bad = 0;

  snn_spike_axis_tx dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .spike_valid  (spike_valid),
    .spike        (spike),
    .busy         (busy),
    .done         (done),
    .m_axis_tdata (m_axis_tdata),
    .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready),
    .m_axis_tlast (m_axis_tlast)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_win();
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("busy_after_start", busy, 1);
  endtask

  task automatic step(input logic [3:0] s, input int gap, input bit last);
    spike_valid = 1'b1;
    spike = s;
    tick();
    spike_valid = 1'b0;
    spike = '0;
    chk("tvalid_after_step", m_axis_tvalid, last);
    repeat (gap) begin
      tick();
      chk("tvalid_in_gap", m_axis_tvalid, 0);
    end
  endtask

  task automatic drain(input int ev[4], input int stall_beat, input bit chain);
    int n;
    for (int b = 0; b < 4; b++) begin
      n = 0;
      while (!m_axis_tvalid && n < 20) begin
        tick();
        n++;
      end
      chk($sformatf("beat%0d_wait", b), n, 0);
      if (b == stall_beat) begin
        m_axis_tready = 1'b0;
        repeat (3) begin
          tick();
          chk($sformatf("beat%0d_hold_data", b), m_axis_tdata, ev[b]);
          chk($sformatf("beat%0d_hold_last", b), m_axis_tlast, int'(b == 3));
          chk($sformatf("beat%0d_hold_valid", b), m_axis_tvalid, 1);
        end
      end
      chk($sformatf("beat%0d_data", b), m_axis_tdata, ev[b]);
      chk($sformatf("beat%0d_last", b), m_axis_tlast, int'(b == 3));
      chk($sformatf("beat%0d_no_done", b), done, 0);
      m_axis_tready = 1'b1;
      tick();
      m_axis_tready = 1'b0;
    end
    chk("done_pulse", done, 1);
    chk("tvalid_at_done", m_axis_tvalid, 0);
    chk("busy_at_done", busy, 0);
    if (chain) start = 1'b1;
    tick();
    start = 1'b0;
    chk("done_once", done, 0);
    if (chain) chk("busy_chained", busy, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    start = 1'b0;
    spike_valid = 1'b0;
    spike = '0;
    m_axis_tready = 1'b0;
    repeat (3) tick();
    reset = 1'b0;
    tick();
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_tvalid", m_axis_tvalid, 0);
    chk("rst_tlast", m_axis_tlast, 0);
    chk("rst_tdata", m_axis_tdata, 0);

    // No spikes: every neuron reports 5.
    start_win();
    for (int s = 0; s < 5; s++) step(4'b0000, 0, s == 4);
    drain('{5, 5, 5, 5}, -1, 1'b0);

    // Neuron 0 at step 0, neuron 3 at step 4.
    start_win();
    step(4'b0001, 0, 1'b0);
    step(4'b0000, 0, 1'b0);
    step(4'b0000, 0, 1'b0);
    step(4'b0000, 0, 1'b0);
    step(4'b1000, 0, 1'b1);
    drain('{0, 5, 5, 4}, -1, 1'b0);

    // Neuron 1 at steps 1..3 keeps 1; stray start mid-capture is ignored.
    start_win();
    step(4'b0000, 0, 1'b0);
    step(4'b0010, 0, 1'b0);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("busy_stray_start", busy, 1);
    step(4'b0010, 0, 1'b0);
    step(4'b0010, 0, 1'b0);
    step(4'b0000, 0, 1'b1);
    drain('{5, 1, 5, 5}, -1, 1'b0);

    // Valid every third cycle; beat 2 stalled for 3 cycles.
    start_win();
    step(4'b0100, 2, 1'b0);
    step(4'b0000, 2, 1'b0);
    step(4'b0001, 2, 1'b0);
    step(4'b1111, 2, 1'b0);
    step(4'b0000, 0, 1'b1);
    drain('{2, 3, 0, 3}, 2, 1'b0);

    // Reset while beat 1 is presented.
    start_win();
    step(4'b1111, 0, 1'b0);
    for (int s = 1; s < 5; s++) step(4'b0000, 0, s == 4);
    chk("rs_beat0", m_axis_tdata, 0);
    m_axis_tready = 1'b1;
    tick();
    m_axis_tready = 1'b0;
    chk("rs_beat1_valid", m_axis_tvalid, 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("rs_tvalid", m_axis_tvalid, 0);
    chk("rs_busy", busy, 0);
    chk("rs_done", done, 0);
    chk("rs_tlast", m_axis_tlast, 0);
    tick();
    chk("rs_done_after", done, 0);
    start_win();
    for (int s = 0; s < 5; s++) step(4'b0000, 0, s == 4);
    drain('{5, 5, 5, 5}, -1, 1'b0);

    // Back-to-back: start accepted in the done cycle, registers reinitialised.
    start_win();
    step(4'b0000, 0, 1'b0);
    step(4'b1111, 0, 1'b0);
    step(4'b0000, 0, 1'b0);
    step(4'b0000, 0, 1'b0);
    step(4'b0000, 0, 1'b1);
    drain('{1, 1, 1, 1}, -1, 1'b1);
    for (int s = 0; s < 5; s++) step((s == 4) ? 4'b0010 : 4'b0000, 0, s == 4);
    drain('{5, 4, 5, 5}, -1, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
